pkt_deser: RTL and testbench

//   Serial-to-parallel packet receiver; the far end of the Pkt_reg serial link.
//   A start pulse arms capture of PKT_W serial bits, MSB first, into a shift register.
//   The assembled word is published on dout with a valid/ack handshake.

---
 rtl/pkt_deser_pkg.sv | 12 +
 rtl/pkt_deser_if.sv | 29 ++
 rtl/pkt_deser.sv | 120 ++++++++++++
 tb/tb_pkt_deser.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pkt_deser_pkg.sv
// Shared definitions for the pkt_deser serial packet receiver: default width and FSM encoding.
package pkt_deser_pkg;

  localparam int unsigned PKT_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_e;

endpackage

// File: rtl/pkt_deser_if.sv
// Packet receiver bus: serial input, start/ack controls and the published word with status.
interface pkt_deser_if
  import pkt_deser_pkg::*;
#(
  parameter int unsigned PKT_W = PKT_W_DEF
);

  logic             pkt_start;
  logic             din;
  logic             pkt_ack;
  logic [PKT_W-1:0] dout;
  logic             pkt_vld;
  logic             busy;
  logic             ovr;
  logic             par_err;

  // Link/consumer side
  modport master (
    output pkt_start, din, pkt_ack,
    input  dout, pkt_vld, busy, ovr, par_err
  );

  // Receiver side
  modport slave (
    input  pkt_start, din, pkt_ack,
    output dout, pkt_vld, busy, ovr, par_err
  );

endinterface

// File: rtl/pkt_deser.sv
// Serial-to-parallel packet receiver: MSB-first capture of PKT_W bits, valid/ack publish.
// Optional trailing even-parity bit and par_err output when PKT_PARITY_EN is defined.
module pkt_deser
  import pkt_deser_pkg::*;
#(
  parameter int unsigned PKT_W = PKT_W_DEF
)(
  input  logic       clk,
  input  logic       rst,
  pkt_deser_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(PKT_W + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PKT_W-1:0] shreg_q, shreg_d;
  logic [PKT_W-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             ovr_q, ovr_d;
  logic             commit;
  logic [PKT_W-1:0] word;
`ifdef PKT_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;
    commit  = 1'b0;
    word    = shreg_q;
`ifdef PKT_PARITY_EN
    par_err_d = par_err_q;
`endif

    case (state_q)
      ST_IDLE: ;
      ST_SHIFT: begin
        shreg_d = {shreg_q[PKT_W-2:0], bus.din};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PKT_W - 1)) begin
`ifdef PKT_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_IDLE;
          commit  = 1'b1;
          word    = shreg_d;
`endif
        end
      end
`ifdef PKT_PARITY_EN
      ST_PAR: begin
        state_d   = ST_IDLE;
        commit    = 1'b1;
        word      = shreg_q;
        par_err_d = ^{shreg_q, bus.din};
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // A start pulse always (re)arms capture; on the commit edge it chains back-to-back.
    if (bus.pkt_start) begin
      state_d = ST_SHIFT;
      cnt_d   = '0;
    end

    if (commit) begin
      dout_d = word;
      vld_d  = 1'b1;
      if (vld_q && !bus.pkt_ack) ovr_d = 1'b1;
    end else if (vld_q && bus.pkt_ack) begin
      vld_d = 1'b0;
      ovr_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef PKT_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= par_err_d;
  end
  assign bus.par_err = par_err_q;
`else
  assign bus.par_err = 1'b0;
`endif

  assign bus.dout    = dout_q;
  assign bus.pkt_vld = vld_q;
  assign bus.busy    = busy_q;
  assign bus.ovr     = ovr_q;

endmodule

// File: tb/tb_pkt_deser.sv
// Directed bench for pkt_deser: reset, basic capture, back-to-back, ack-on-commit,
// restart, mid-capture reset and (with PKT_PARITY_EN) parity checking.
module tb_pkt_deser;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pkt_deser_if #(.PKT_W(64)) bus ();

  pkt_deser #(.PKT_W(64)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bits 63..1 (plus bit 0 when a parity cycle follows); the last cycle is sent separately.
  task automatic send_head(input logic [63:0] w);
    for (int i = 63; i >= 1; i--) begin
      bus.din = w[i];
      step();
    end
`ifdef PKT_PARITY_EN
    bus.din = w[0];
    step();
`endif
  endtask

  // Commit-edge cycle with optional start/ack; flip corrupts the parity bit.
  task automatic last_cycle(input logic [63:0] w, input logic start, input logic ack,
                            input logic flip);
`ifdef PKT_PARITY_EN
    bus.din = (^w) ^ flip;
`else
    bus.din = w[0] ^ (flip & 1'b0);
`endif
    bus.pkt_start = start;
    bus.pkt_ack   = ack;
    step();
    bus.pkt_start = 1'b0;
    bus.pkt_ack   = 1'b0;
  endtask

  task automatic start_pulse();
    bus.pkt_start = 1'b1;
    step();
    bus.pkt_start = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.pkt_ack = 1'b1;
    step();
    bus.pkt_ack = 1'b0;
  endtask

  initial begin
    logic [63:0] w1, w2, w3, w4, w5;
    w1 = 64'hAAAA_AAAA_AAAA_AAAA;
    w2 = 64'h0123_4567_89AB_CDEF;
    w3 = 64'hDEAD_BEEF_CAFE_F00D;
    w4 = 64'h0F0F_3C3C_5A5A_9669;
    w5 = 64'hFFFF_0000_FFFF_0000;

    // T1 reset with din toggling
    rst = 1'b1;
    bus.pkt_start = 1'b0;
    bus.din       = 1'b0;
    bus.pkt_ack   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.din = ~bus.din;
      step();
    end
    chk("rst_dout", bus.dout, 64'h0);
    chk("rst_vld", 64'(bus.pkt_vld), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_ovr", 64'(bus.ovr), 64'h0);
    chk("rst_par", 64'(bus.par_err), 64'h0);
    rst = 1'b0;
    step();
    chk("post_rst_busy", 64'(bus.busy), 64'h0);
    chk("post_rst_vld", 64'(bus.pkt_vld), 64'h0);

    // T2 basic capture and ack
    start_pulse();
    chk("t2_busy", 64'(bus.busy), 64'h1);
    send_head(w1);
    chk("t2_vld_early", 64'(bus.pkt_vld), 64'h0);
    last_cycle(w1, 1'b0, 1'b0, 1'b0);
    chk("t2_dout", bus.dout, w1);
    chk("t2_vld", 64'(bus.pkt_vld), 64'h1);
    chk("t2_busy_done", 64'(bus.busy), 64'h0);
    chk("t2_ovr", 64'(bus.ovr), 64'h0);
    chk("t2_par", 64'(bus.par_err), 64'h0);
    ack_pulse();
    chk("t2_ack_vld", 64'(bus.pkt_vld), 64'h0);
    chk("t2_ack_dout", bus.dout, w1);
    ack_pulse();
    chk("t2_stray_ack_vld", 64'(bus.pkt_vld), 64'h0);
    chk("t2_stray_ack_ovr", 64'(bus.ovr), 64'h0);

    // T3 back-to-back with no ack -> overrun
    start_pulse();
    send_head(w3);
    last_cycle(w3, 1'b1, 1'b0, 1'b0);
    chk("t3_dout1", bus.dout, w3);
    chk("t3_vld1", 64'(bus.pkt_vld), 64'h1);
    chk("t3_busy_chain", 64'(bus.busy), 64'h1);
    chk("t3_ovr1", 64'(bus.ovr), 64'h0);
    send_head(w2);
    chk("t3_dout_hold", bus.dout, w3);
    last_cycle(w2, 1'b0, 1'b0, 1'b0);
    chk("t3_dout2", bus.dout, w2);
    chk("t3_vld2", 64'(bus.pkt_vld), 64'h1);
    chk("t3_ovr2", 64'(bus.ovr), 64'h1);
    ack_pulse();
    chk("t3_ack_ovr", 64'(bus.ovr), 64'h0);
    chk("t3_ack_vld", 64'(bus.pkt_vld), 64'h0);

    // T4 ack coincides with the second commit
    start_pulse();
    send_head(w1);
    last_cycle(w1, 1'b1, 1'b0, 1'b0);
    send_head(w4);
    last_cycle(w4, 1'b0, 1'b1, 1'b0);
    chk("t4_vld", 64'(bus.pkt_vld), 64'h1);
    chk("t4_ovr", 64'(bus.ovr), 64'h0);
    chk("t4_dout", bus.dout, w4);
    ack_pulse();
    chk("t4_ack_vld", 64'(bus.pkt_vld), 64'h0);

    // T5 restart at bit 20
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      bus.din = w3[63-i];
      step();
    end
    start_pulse();
    send_head(w5);
    chk("t5_vld_early", 64'(bus.pkt_vld), 64'h0);
    last_cycle(w5, 1'b0, 1'b0, 1'b0);
    chk("t5_dout", bus.dout, w5);
    chk("t5_vld", 64'(bus.pkt_vld), 64'h1);

    // T5 reset at bit 30 (pkt_vld still set from the restart word)
    start_pulse();
    for (int i = 0; i < 30; i++) begin
      bus.din = w2[63-i];
      step();
    end
    rst = 1'b1;
    #2;
    chk("t5_arst_dout", bus.dout, 64'h0);
    chk("t5_arst_vld", 64'(bus.pkt_vld), 64'h0);
    chk("t5_arst_busy", 64'(bus.busy), 64'h0);
    rst = 1'b0;
    for (int i = 30; i < 64; i++) begin
      bus.din = w2[63-i];
      step();
    end
    for (int i = 0; i < 4; i++) step();
    chk("t5_post_vld", 64'(bus.pkt_vld), 64'h0);
    chk("t5_post_busy", 64'(bus.busy), 64'h0);
    chk("t5_post_ovr", 64'(bus.ovr), 64'h0);

`ifdef PKT_PARITY_EN
    // T6 parity good then bad
    start_pulse();
    send_head(64'h1);
    last_cycle(64'h1, 1'b0, 1'b0, 1'b0);
    chk("t6_good_par", 64'(bus.par_err), 64'h0);
    chk("t6_good_dout", bus.dout, 64'h1);
    ack_pulse();
    start_pulse();
    send_head(64'h1);
    chk("t6_vld_early", 64'(bus.pkt_vld), 64'h0);
    last_cycle(64'h1, 1'b0, 1'b0, 1'b1);
    chk("t6_bad_par", 64'(bus.par_err), 64'h1);
    chk("t6_bad_vld", 64'(bus.pkt_vld), 64'h1);
    chk("t6_bad_dout", bus.dout, 64'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
